// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state type and datapath widths for the arbitrated calculator.
// Imported by the calculator and by calc_arbiter.
package calc_pkg;
    localparam int OPND_W  = 4;
    localparam int RES_W   = 8;
    localparam int OP_W    = 3;
    localparam int NUM_REQ = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } calc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Operands captured from the winning requester at grant time
    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        calc_op_e          oper;
        logic              id;
    } calc_req_t;
endpackage

// File: rtl/calculator.sv
// Combinational 4-bit calculator producing an 8-bit result.
// Divide by zero yields zero; the caller flags the error.
module calculator
    import calc_pkg::*;
(
    input  logic [OPND_W-1:0] i_a,
    input  logic [OPND_W-1:0] i_b,
    input  logic [OP_W-1:0]   i_oper,
    output logic [RES_W-1:0]  o_out
);
    logic [RES_W-1:0] w_a;
    logic [RES_W-1:0] w_b;

    assign w_a = {{(RES_W-OPND_W){1'b0}}, i_a};
    assign w_b = {{(RES_W-OPND_W){1'b0}}, i_b};

    always_comb begin
        o_out = '0;
        case (calc_op_e'(i_oper))
            OP_ADD:  o_out = w_a + w_b;
            OP_SUB:  o_out = w_a - w_b;
            OP_MUL:  o_out = w_a * w_b;
            OP_DIV:  o_out = (i_b == '0) ? '0 : w_a / w_b;
            OP_AND:  o_out = w_a & w_b;
            OP_OR:   o_out = w_a | w_b;
            OP_XOR:  o_out = w_a ^ w_b;
            OP_NOT:  o_out = {{(RES_W-OPND_W){1'b0}}, ~i_a};
            default: o_out = '0;
        endcase
    end
endmodule

// File: rtl/calc_arbiter.sv
// Round-robin arbiter sharing one calculator between two requesters.
// IDLE grants and latches operands, EXEC registers the result, RESP holds it until accepted.
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int CNT_W = 8
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*OPND_W-1:0]   req_a,
    input  logic [NUM_REQ*OPND_W-1:0]   req_b,
    input  logic [NUM_REQ*OP_W-1:0]     req_oper,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_id,
    output logic [RES_W-1:0]            rsp_data,
    output logic                        rsp_err,
    output logic                        busy,
    output logic [CNT_W-1:0]            op_count
);
    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_ptr;
    calc_req_t        r_req;
    logic [RES_W-1:0] r_rsp_data;
    logic             r_rsp_id;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_win;
    logic             w_gnt;
    logic             w_done;
    logic [RES_W-1:0] w_calc_out;

    // Contention goes to the requester not granted last; a lone requester always wins
    always_comb begin
        if (&req_valid) w_win = ~r_ptr;
        else            w_win = req_valid[1];
    end

    assign w_gnt  = (r_state == ST_IDLE) && (|req_valid);
    assign w_done = (r_state == ST_RESP) && rsp_ready;

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt) begin
                    req_ready   = w_win ? 2'b10 : 2'b01;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 1'b1;
            r_req      <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_gnt) begin
                r_ptr       <= w_win;
                r_req.id    <= w_win;
                r_req.a     <= w_win ? req_a[7:4]    : req_a[3:0];
                r_req.b     <= w_win ? req_b[7:4]    : req_b[3:0];
                r_req.oper  <= calc_op_e'(w_win ? req_oper[5:3] : req_oper[2:0]);
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data <= w_calc_out;
                r_rsp_id   <= r_req.id;
                r_rsp_err  <= (r_req.oper == OP_DIV) && (r_req.b == '0);
            end
            if (w_done) r_cnt <= r_cnt + 1'b1;
        end
    end

    calculator u_calc (
        .i_a    (r_req.a),
        .i_b    (r_req.b),
        .i_oper (r_req.oper),
        .o_out  (w_calc_out)
    );

    assign rsp_valid = (r_state == ST_RESP);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;
    assign op_count  = r_cnt;
endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: table of single requests plus hand sequences for
// backpressure, late drop, reset mid-operation, contention and counter wrap.
module tb_calc_arbiter;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [7:0]       req_a, req_b;
    logic [5:0]       req_oper;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [7:0]       rsp_data;
    logic [CNT_W-1:0] op_count;

    calc_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_oper(req_oper),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [7:0] d;
        logic       e;
    } vec_t;

    typedef struct {
        logic       id;
        logic [7:0] d;
        logic       e;
    } exp_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_grants = 0;
    int n_resps = 0;
    exp_t sb[$];
    logic gq[$];
    int   gcycq[$];
    logic [7:0] rlog[$];
    logic       m_ptr = 1'b1;
    logic       m_busy = 1'b0;
    int         m_gcyc = 0;
    int         m_cnt = 0;
    exp_t       last_rsp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mcalc(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int ia, ib, r;
        ia = a;
        ib = b;
        case (op)
            3'd0:    r = ia + ib;
            3'd1:    r = ia - ib;
            3'd2:    r = ia * ib;
            3'd3:    r = (ib == 0) ? 0 : ia / ib;
            3'd4:    r = ia & ib;
            3'd5:    r = ia | ib;
            3'd6:    r = ia ^ ib;
            default: r = (~ia) & 15;
        endcase
        return r[7:0];
    endfunction

    always @(posedge clk) cyc++;

    // Reference model and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            logic [1:0] exp_rdy;
            logic       w;
            exp_t       x;
            logic [3:0] a, b;
            logic [2:0] op;
            w = (req_valid == 2'b11) ? ~m_ptr : req_valid[1];
            exp_rdy = (!m_busy && req_valid != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, m_busy && (cyc - m_gcyc >= 2));
            chk("op_count", op_count, m_cnt % (1 << CNT_W));
            if (exp_rdy != 2'b00) begin
                a  = w ? req_a[7:4] : req_a[3:0];
                b  = w ? req_b[7:4] : req_b[3:0];
                op = w ? req_oper[5:3] : req_oper[2:0];
                x.id = w;
                x.d  = mcalc(a, b, op);
                x.e  = (op == 3'd3) && (b == 4'd0);
                sb.push_back(x);
                gq.push_back(w);
                gcycq.push_back(cyc);
                m_ptr  = w;
                m_busy = 1'b1;
                m_gcyc = cyc;
                n_grants++;
            end else if (rsp_valid && rsp_ready && m_busy) begin
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    x = sb.pop_front();
                    chk("rsp_id", rsp_id, x.id);
                    chk("rsp_data", rsp_data, x.d);
                    chk("rsp_err", rsp_err, x.e);
                end
                last_rsp.id = rsp_id;
                last_rsp.d  = rsp_data;
                last_rsp.e  = rsp_err;
                rlog.push_back(rsp_data);
                m_cnt++;
                m_busy = 1'b0;
                n_resps++;
            end
        end
    end

    task automatic wait_grants(input int target, input string name);
        int t = 0;
        while (n_grants < target && t < 40) begin @(posedge clk); t++; end
        chk(name, n_grants, target);
    endtask

    task automatic wait_resps(input int target, input string name);
        int t = 0;
        while (n_resps < target && t < 40) begin @(posedge clk); t++; end
        chk(name, n_resps, target);
    endtask

    task automatic drive_one(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        req_valid = id ? 2'b10 : 2'b01;
        req_a     = id ? {a, 4'h6} : {4'h6, a};
        req_b     = id ? {b, 4'h2} : {4'h2, b};
        req_oper  = id ? {op, 3'd2} : {3'd2, op};
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_op_count"}, op_count, 0);
    endtask

    vec_t vecs[10];

    initial begin
        int g0, r0;
        vecs[0] = '{1'b0, 4'd9,  4'd3,  3'd0, 8'd12,  1'b0};
        vecs[1] = '{1'b1, 4'd9,  4'd3,  3'd1, 8'd6,   1'b0};
        vecs[2] = '{1'b0, 4'd9,  4'd3,  3'd2, 8'd27,  1'b0};
        vecs[3] = '{1'b1, 4'd9,  4'd0,  3'd3, 8'h00,  1'b1};
        vecs[4] = '{1'b0, 4'd9,  4'd3,  3'd3, 8'd3,   1'b0};
        vecs[5] = '{1'b1, 4'd5,  4'd12, 3'd4, 8'd4,   1'b0};
        vecs[6] = '{1'b0, 4'd5,  4'd10, 3'd5, 8'd15,  1'b0};
        vecs[7] = '{1'b1, 4'd15, 4'd5,  3'd6, 8'd10,  1'b0};
        vecs[8] = '{1'b0, 4'd5,  4'd7,  3'd7, 8'd10,  1'b0};
        vecs[9] = '{1'b1, 4'd15, 4'd15, 3'd2, 8'd225, 1'b0};

        rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; req_oper = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Table of single requests, response checked against fixed results
        foreach (vecs[i]) begin
            g0 = n_grants; r0 = n_resps;
            @(posedge clk); #1 drive_one(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
            wait_grants(g0 + 1, "vec_grant");
            #1 req_valid = 2'b00;
            wait_resps(r0 + 1, "vec_resp");
            chk("vec_id", last_rsp.id, vecs[i].id);
            chk("vec_data", last_rsp.d, vecs[i].d);
            chk("vec_err", last_rsp.e, vecs[i].e);
        end

        // Requester 1 raises and drops valid while busy: never served
        g0 = n_grants; r0 = n_resps;
        @(posedge clk); #1 drive_one(1'b0, 4'd2, 4'd3, 3'd0);
        wait_grants(g0 + 1, "drop_grant");
        #1 req_valid = 2'b10;
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (6) @(posedge clk);
        chk("drop_not_served", n_grants - g0, 1);
        chk("drop_resp", n_resps - r0, 1);

        // Backpressure with requester 1 waiting
        g0 = n_grants; r0 = n_resps;
        rsp_ready = 1'b0;
        @(posedge clk); #1 drive_one(1'b0, 4'd9, 4'd3, 3'd0);
        req_a[7:4] = 4'd5; req_b[7:4] = 4'd10; req_oper[5:3] = 3'd5;
        wait_grants(g0 + 1, "bp_grant");
        #1 req_valid = 2'b10;
        begin
            int t = 0;
            @(negedge clk);
            while (!rsp_valid && t < 10) begin @(negedge clk); t++; end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 8'd12);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready_low", req_ready, 2'b00);
            chk("bp_count", op_count, (m_cnt % (1 << CNT_W)));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_grants(g0 + 2, "bp_waiter_grant");
        #1 req_valid = 2'b00;
        wait_resps(r0 + 2, "bp_resps");
        chk("bp_waiter_id", last_rsp.id, 1);
        chk("bp_waiter_data", last_rsp.d, 8'd15);

        // Reset during EXEC discards the operation
        g0 = n_grants;
        @(posedge clk); #1 drive_one(1'b1, 4'd9, 4'd3, 3'd0);
        wait_grants(g0 + 1, "rst_grant");
        #1 req_valid = 2'b00;
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        sb.delete(); gq.delete(); gcycq.delete(); rlog.delete();
        m_ptr = 1'b1; m_busy = 1'b0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Contention after reset: alternating grants, five ops wrap the counter
        g0 = n_grants; r0 = n_resps;
        @(posedge clk); #1;
        req_valid = 2'b11;
        req_a = {4'd9, 4'd9}; req_b = {4'd3, 4'd3}; req_oper = {3'd1, 3'd2};
        wait_grants(g0 + 5, "cont_grants");
        #1 req_valid = 2'b00;
        wait_resps(r0 + 5, "cont_resps");
        chk("cont_len", gq.size(), 5);
        if (gq.size() == 5) begin
            chk("cont_g0", gq[0], 0);
            chk("cont_g1", gq[1], 1);
            chk("cont_g2", gq[2], 0);
            chk("cont_g3", gq[3], 1);
            chk("cont_g4", gq[4], 0);
            for (int k = 1; k < 5; k++) chk("cont_spacing", gcycq[k] - gcycq[k-1], 3);
        end
        chk("cont_rlen", rlog.size(), 5);
        if (rlog.size() == 5) begin
            chk("cont_d0", rlog[0], 8'd27);
            chk("cont_d1", rlog[1], 8'd6);
            chk("cont_d4", rlog[4], 8'd27);
        end
        @(negedge clk);
        chk("wrap_count", op_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter: CNT_W, default 8, width of the completed-operation counter.
REQ-002 Port: clk  input  1  single clock, all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 Port: req_ready  output  2  per-requester accept strobe; at most one bit high per cycle.
REQ-006 Port: req_a  input  8  operand A; bits [4i+3:4i] belong to requester i.
REQ-007 Port: req_b  input  8  operand B; bits [4i+3:4i] belong to requester i.
REQ-008 Port: req_oper  input  6  opcode; bits [3i+2:3i] belong to requester i.
REQ-009 Port: rsp_valid  output  1  response valid.
REQ-010 Port: rsp_ready  input  1  response consumer ready.
REQ-011 Port: rsp_id  output  1  index of the requester that owns the response.
REQ-012 Port: rsp_data  output  8  calculator result.
REQ-013 Port: rsp_err  output  1  error flag; set for divide-by-zero.
REQ-014 Port: busy  output  1  high in any state other than IDLE.
REQ-015 Port: op_count  output  CNT_W  count of completed responses.

Function
REQ-016 The block SHALL share one calculator instance (4-bit a and b, 3-bit oper, 8-bit out) between two requesters through a three-state FSM: IDLE, EXEC, RESP.
REQ-017 In IDLE with any req_valid bit high, the block SHALL assert the winner's req_ready in the same cycle, latch its a, b and oper, and move to EXEC.
REQ-018 Arbitration SHALL be round-robin: if both requesters are valid, grant the one that was not granted last. The last-grant pointer resets to 1, so requester 0 wins the first contention.
REQ-019 The pointer SHALL update only on a grant; a lone valid requester SHALL be granted regardless of the pointer.
REQ-020 In EXEC, the latched operands SHALL drive the calculator; on the next edge the block SHALL register out into rsp_data, the winner into rsp_id and the error status into rsp_err, then move to RESP.
REQ-021 In RESP, rsp_valid SHALL be high and rsp_data, rsp_id and rsp_err SHALL stay stable until rsp_ready is high.
REQ-022 When rsp_valid and rsp_ready are both high, the block SHALL increment op_count (wrapping modulo 2^CNT_W) and return to IDLE.
REQ-023 Latency SHALL be: grant at cycle N, rsp_valid high from cycle N+2; with rsp_ready held high the earliest next grant is N+3.
REQ-024 req_ready SHALL be low in EXEC and RESP; requests arriving then SHALL wait and are not lost, because they are level-held valid.
REQ-025 For oper DIV with b=0, rsp_data SHALL be 8'h00 and rsp_err SHALL be 1; for every other operation rsp_err SHALL be 0.
REQ-026 A requester that drops req_valid before its grant SHALL not be served.

Reset
REQ-027 When rst_n is low, the block SHALL immediately force: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, op_count=0, last-grant pointer=1.
REQ-028 Reset asserted during EXEC or RESP SHALL discard the in-flight operation without incrementing op_count.

Structure
REQ-029 A shared package calc_pkg SHALL hold the opcode constants (ADD=000, SUB=001, MUL=010, DIV=011, AND=100, OR=101, XOR=110, NOT=111), the FSM state type, and the operand/result widths (4 and 8).
REQ-030 The existing calculator module SHALL be instantiated unchanged as the sole sub-module; arbitration and the FSM SHALL live in calc_arbiter.

Verification
REQ-031 Single request: req_valid=01, a=9, b=3, oper=ADD -> req_ready=01 at N, rsp_valid at N+2 with rsp_data=8'd12, rsp_id=0, rsp_err=0, op_count=1.
REQ-032 Contention: both valid continuously (req0 9 MUL 3, req1 9 SUB 3), rsp_ready=1 -> grants alternate 0,1,0,1; responses 8'd27 (id 0) and 8'd6 (id 1).
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data held stable, req_ready=00, op_count unchanged until the handshake.
REQ-034 Divide by zero: a=9, b=0, oper=DIV -> rsp_data=8'h00, rsp_err=1; the next request, 9 DIV 3, -> rsp_data=3, rsp_err=0.
REQ-035 Reset mid-operation: rst_n low during EXEC -> all outputs zero immediately; after release, req0 and req1 both valid -> requester 0 granted first.
REQ-036 Counter wrap: with CNT_W=2, five completed responses -> op_count=1.
